// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings for the RV32M multiply/divide unit
// (funct3 codes, FSM states, iteration count).
package muldiv_pkg;

   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   localparam int ITER_COUNT = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: issue operands in, register-file write port out.
// The unit is the slave; the issuing control is the master.
interface muldiv_if #(
   parameter int XLEN = 32,
   parameter int REGW = 6
);
   logic            start;
   logic            flush;
   logic [2:0]      funct3;
   logic [XLEN-1:0] Data1;
   logic [XLEN-1:0] Data2;
   logic [REGW-1:0] rd;
   logic            busy;
   logic            done;
   logic            RegWrite;
   logic [REGW-1:0] WriteReg;
   logic [XLEN-1:0] WriteData;

   modport master (
      output start, flush, funct3, Data1, Data2, rd,
      input  busy, done, RegWrite, WriteReg, WriteData
   );

   modport slave (
      input  start, flush, funct3, Data1, Data2, rd,
      output busy, done, RegWrite, WriteReg, WriteData
   );
endinterface

// File: rtl/muldiv_div_step.sv
// muldiv_div_step: one combinational restoring-divide step.
// Shifts the next dividend bit into the remainder and subtracts the divisor if it fits.
module muldiv_div_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] rem_in,
   input  logic [W-1:0] divisor,
   input  logic         bit_in,
   output logic [W-1:0] rem_out,
   output logic         q_bit
);
   logic [W:0]   shifted;
   logic [W+1:0] diff;

   // rem_in < divisor always holds, so the shifted value fits in W+1 bits
   assign shifted = {rem_in, bit_in};
   assign diff    = {1'b0, shifted} - {2'b00, divisor};
   assign q_bit   = ~diff[W+1];
   assign rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide driving the register-file write port.
// Define MULDIV_FAST_MUL_EN to compute MUL* ops with a single-cycle combinational multiplier.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 6
) (
   input  logic    clock,
   input  logic    reset_n,
   muldiv_if.slave bus
);
   state_t            state, state_nx;
   logic [5:0]        cnt;
   logic [2:0]        op;
   logic [REGW-1:0]   rd_q;
   logic              res_neg;
   logic [XLEN-1:0]   b_q, acc_hi, acc_lo;
   logic              done_q, wr_q;
   logic [REGW-1:0]   wreg_q;
   logic [XLEN-1:0]   wdata_q;

   logic              sgn_a, sgn_b, neg_a, neg_b, res_neg_nx;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     mul_sum;
   logic [XLEN-1:0]   dv_rem, step_hi, step_lo, fin_hi, fin_lo;
   logic              dv_q, last;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s, rem_s, result;

   // Work on magnitudes; res_neg remembers how to fix the sign at the end
   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      case (bus.funct3)
         F3_MULH, F3_DIV, F3_REM: begin sgn_a = 1'b1; sgn_b = 1'b1; end
         F3_MULHSU:               sgn_a = 1'b1;
         default: ;
      endcase
      neg_a = sgn_a & bus.Data1[XLEN-1];
      neg_b = sgn_b & bus.Data2[XLEN-1];
      mag_a = neg_a ? -bus.Data1 : bus.Data1;
      mag_b = neg_b ? -bus.Data2 : bus.Data2;
      // divide-by-zero keeps quotient all-ones regardless of dividend sign
      if (bus.funct3 == F3_REM)      res_neg_nx = neg_a;
      else if (bus.funct3 == F3_DIV) res_neg_nx = (neg_a ^ neg_b) & (|bus.Data2);
      else                           res_neg_nx = neg_a ^ neg_b;
   end

   // Multiply: {acc_hi,acc_lo} is the product register, multiplier shifts out of acc_lo.
   // Divide: acc_hi is the partial remainder, dividend shifts out / quotient shifts into acc_lo.
   assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);

   muldiv_div_step #(.W(XLEN)) u_div_step (
      .rem_in  (acc_hi),
      .divisor (b_q),
      .bit_in  (acc_lo[XLEN-1]),
      .rem_out (dv_rem),
      .q_bit   (dv_q)
   );

   assign step_hi = op[2] ? dv_rem : mul_sum[XLEN:1];
   assign step_lo = op[2] ? {acc_lo[XLEN-2:0], dv_q} : {mul_sum[0], acc_lo[XLEN-1:1]};
   assign last    = (cnt == 6'(ITER_COUNT - 1));

`ifdef MULDIV_FAST_MUL_EN
   logic fast_q;
   // A fast product already sits in acc; its single CALC pass only registers the result
   assign fin_hi = fast_q ? acc_hi : step_hi;
   assign fin_lo = fast_q ? acc_lo : step_lo;
`else
   assign fin_hi = step_hi;
   assign fin_lo = step_lo;
`endif

   assign prod_s = res_neg ? -{fin_hi, fin_lo} : {fin_hi, fin_lo};
   assign quo_s  = res_neg ? -fin_lo : fin_lo;
   assign rem_s  = res_neg ? -fin_hi : fin_hi;

   always_comb begin
      result = quo_s;
      case (op)
         F3_MUL:                       result = prod_s[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: result = prod_s[2*XLEN-1:XLEN];
         F3_REM, F3_REMU:              result = rem_s;
         default:                      result = quo_s;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start && !bus.flush) state_nx = CALC;
         CALC:    if (bus.flush) state_nx = IDLE;
                  else if (last) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         cnt     <= '0;
         op      <= F3_MUL;
         rd_q    <= '0;
         res_neg <= 1'b0;
         b_q     <= '0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         done_q  <= 1'b0;
         wr_q    <= 1'b0;
         wreg_q  <= '0;
         wdata_q <= '0;
`ifdef MULDIV_FAST_MUL_EN
         fast_q  <= 1'b0;
`endif
      end else begin
         state  <= state_nx;
         done_q <= 1'b0;
         wr_q   <= 1'b0;
         case (state)
            IDLE: if (bus.start && !bus.flush) begin
               op      <= bus.funct3;
               rd_q    <= bus.rd;
               res_neg <= res_neg_nx;
               cnt     <= '0;
               acc_hi  <= '0;
               acc_lo  <= bus.funct3[2] ? mag_a : mag_b;
               b_q     <= bus.funct3[2] ? mag_b : mag_a;
`ifdef MULDIV_FAST_MUL_EN
               fast_q  <= ~bus.funct3[2];
               if (!bus.funct3[2]) begin
                  {acc_hi, acc_lo} <= mag_a * mag_b;
                  cnt              <= 6'(ITER_COUNT - 1);
               end
`endif
            end
            CALC: if (!bus.flush) begin
               acc_hi <= step_hi;
               acc_lo <= step_lo;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  done_q  <= 1'b1;
                  wr_q    <= |rd_q;
                  wreg_q  <= rd_q;
                  wdata_q <= result;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_q;
   assign bus.RegWrite  = wr_q;
   assign bus.WriteReg  = wreg_q;
   assign bus.WriteData = wdata_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against a plain-arithmetic
// RV32M model; honours MULDIV_FAST_MUL_EN for expected multiply latency.
module tb_muldiv_unit;
   logic clock;
   logic reset_n;
   int   checks = 0;
   int   errors = 0;

   muldiv_if #(.XLEN(32), .REGW(6)) bus ();

   muldiv_unit #(.XLEN(32), .REGW(6)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // observations of the most recent run_op
   int          o_lat, o_pulses, o_wr, o_fall;
   logic        o_busy0;
   logic [31:0] o_data;
   logic [5:0]  o_reg;

   function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin
            if (b == 32'd0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return $signed(a) / $signed(b);
         end
         3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 32'd0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 32'd0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] f3);
`ifdef MULDIV_FAST_MUL_EN
      return f3[2] ? 32 : 1;
`else
      return (f3 == 3'd0) ? 32 : 32;
`endif
   endfunction

   function automatic logic [31:0] rand_opnd();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   // Issue one op, then watch every edge until busy drops (bounded); start_at/flush_at
   // pulse start/flush so they are sampled at edge k+N.
   task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] r, input int start_at, input int flush_at);
      @(negedge clock);
      bus.start = 1'b1; bus.funct3 = f3; bus.Data1 = a; bus.Data2 = b; bus.rd = r;
      @(posedge clock);
      @(negedge clock);
      o_busy0 = bus.busy; o_lat = -1; o_pulses = 0; o_wr = 0; o_fall = -1;
      bus.start = 1'b0; bus.Data1 = $urandom; bus.Data2 = $urandom;
      for (int e = 1; e <= 45; e++) begin
         bus.start = (e == start_at);
         bus.flush = (e == flush_at);
         if (e == start_at) begin
            bus.funct3 = ~f3; bus.rd = r ^ 6'h2A; bus.Data1 = $urandom; bus.Data2 = $urandom;
         end
         @(posedge clock);
         @(negedge clock);
         if (bus.done === 1'b1) begin
            if (o_lat < 0) o_lat = e;
            o_pulses++; o_data = bus.WriteData; o_reg = bus.WriteReg;
         end
         if (bus.RegWrite === 1'b1) o_wr++;
         if (bus.busy !== 1'b1) begin o_fall = e; break; end
      end
      bus.start = 1'b0;
      bus.flush = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = 3'd0;
      bus.Data1 = '0; bus.Data2 = '0; bus.rd = '0;
      repeat (2) @(posedge clock);
      #1;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
      checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b exp 0", bus.RegWrite); end
      checks++; if (bus.WriteReg !== 6'd0) begin errors++; $display("FAIL reset_writereg got %h exp 0", bus.WriteReg); end
      checks++; if (bus.WriteData !== 32'd0) begin errors++; $display("FAIL reset_writedata got %h exp 0", bus.WriteData); end
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_mul_basic();
      run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 6'd5, -1, -1);
      checks++; if (o_busy0 !== 1'b1) begin errors++; $display("FAIL mul_busy_k got %b exp 1", o_busy0); end
      checks++; if (o_data !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_data got %h exp ffffffeb", o_data); end
      checks++; if (o_reg !== 6'd5) begin errors++; $display("FAIL mul_reg got %0d exp 5", o_reg); end
      checks++; if (o_lat !== exp_lat(3'd0)) begin errors++; $display("FAIL mul_latency got %0d exp %0d", o_lat, exp_lat(3'd0)); end
      checks++; if (o_pulses !== 1 || o_wr !== 1) begin errors++; $display("FAIL mul_pulse got done=%0d wr=%0d exp 1/1", o_pulses, o_wr); end
      checks++; if (o_fall !== exp_lat(3'd0) + 1) begin errors++; $display("FAIL mul_busy_fall got %0d exp %0d", o_fall, exp_lat(3'd0) + 1); end
      checks++; if (bus.WriteData !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_hold got %h exp ffffffeb", bus.WriteData); end
   endtask

   task automatic test_mulh();
      logic [2:0]  f3s  [3] = '{3'd3, 3'd1, 3'd2};
      logic [31:0] exps [3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         run_op(f3s[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd7, -1, -1);
         checks++; if (o_data !== exps[i]) begin errors++; $display("FAIL mulh_f3_%0d got %h exp %h", f3s[i], o_data, exps[i]); end
      end
   endtask

   task automatic test_div();
      logic [2:0]  f3s  [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
      logic [31:0] as   [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
      logic [31:0] exps [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd3, 32'd1};
      for (int i = 0; i < 4; i++) begin
         run_op(f3s[i], as[i], 32'd2, 6'd12, -1, -1);
         checks++; if (o_data !== exps[i]) begin errors++; $display("FAIL div_f3_%0d got %h exp %h", f3s[i], o_data, exps[i]); end
         checks++; if (o_lat !== 32) begin errors++; $display("FAIL div_latency got %0d exp 32", o_lat); end
      end
   endtask

   task automatic test_corner();
      logic [2:0]  f3s  [4] = '{3'd5, 3'd7, 3'd4, 3'd6};
      logic [31:0] as   [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] bs   [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exps [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
      for (int i = 0; i < 4; i++) begin
         run_op(f3s[i], as[i], bs[i], 6'd1, -1, -1);
         checks++; if (o_data !== exps[i]) begin errors++; $display("FAIL corner_%0d got %h exp %h", i, o_data, exps[i]); end
         checks++; if (o_lat !== 32) begin errors++; $display("FAIL corner_latency_%0d got %0d exp 32", i, o_lat); end
      end
   endtask

   task automatic test_rd0();
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      run_op(3'd0, a, b, 6'd0, -1, -1);
      checks++; if (o_pulses !== 1) begin errors++; $display("FAIL rd0_done got %0d pulses exp 1", o_pulses); end
      checks++; if (o_wr !== 0) begin errors++; $display("FAIL rd0_regwrite got %0d pulses exp 0", o_wr); end
      checks++; if (o_data !== ref_op(3'd0, a, b)) begin errors++; $display("FAIL rd0_data got %h exp %h", o_data, ref_op(3'd0, a, b)); end
   endtask

   task automatic test_ignored_start();
      logic [31:0] a, b;
      a = $urandom; b = 32'($urandom_range(1, 1000));
      run_op(3'd5, a, b, 6'd17, 5, -1);
      checks++; if (o_data !== ref_op(3'd5, a, b)) begin errors++; $display("FAIL ign_data got %h exp %h", o_data, ref_op(3'd5, a, b)); end
      checks++; if (o_reg !== 6'd17) begin errors++; $display("FAIL ign_reg got %0d exp 17", o_reg); end
      checks++; if (o_lat !== 32 || o_pulses !== 1) begin errors++; $display("FAIL ign_timing got lat=%0d pulses=%0d exp 32/1", o_lat, o_pulses); end
   endtask

   task automatic test_flush();
      run_op(3'd4, $urandom, $urandom, 6'd9, -1, 10);
      checks++; if (o_fall !== 10) begin errors++; $display("FAIL flush_busy_fall got %0d exp 10", o_fall); end
      checks++; if (o_pulses !== 0 || o_wr !== 0) begin errors++; $display("FAIL flush_write got done=%0d wr=%0d exp 0/0", o_pulses, o_wr); end
      // flush beats a simultaneous start
      @(negedge clock);
      bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd5;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0; bus.flush = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_start got busy=%b exp 0", bus.busy); end
      run_op(3'd5, 32'd100, 32'd7, 6'd9, -1, -1);
      checks++; if (o_data !== 32'd14 || o_wr !== 1) begin errors++; $display("FAIL flush_next got %0d wr=%0d exp 14/1", o_data, o_wr); end
   endtask

   task automatic test_reset_mid();
      run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 6'd5, -1, -1);
      @(negedge clock);
      bus.start = 1'b1; bus.funct3 = 3'd5; bus.Data1 = $urandom; bus.Data2 = 32'd3; bus.rd = 6'd4;
      @(posedge clock);
      @(negedge clock);
      bus.start = 1'b0;
      repeat (8) @(negedge clock);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.RegWrite !== 1'b0)
         begin errors++; $display("FAIL rstmid_ctrl got busy=%b done=%b wr=%b exp 0", bus.busy, bus.done, bus.RegWrite); end
      checks++; if (bus.WriteData !== 32'd0 || bus.WriteReg !== 6'd0)
         begin errors++; $display("FAIL rstmid_data got %h/%0d exp 0/0", bus.WriteData, bus.WriteReg); end
      @(negedge clock);
      reset_n = 1'b1;
      run_op(3'd5, 32'd100, 32'd7, 6'd3, -1, -1);
      checks++; if (o_data !== 32'd14 || o_wr !== 1) begin errors++; $display("FAIL rstmid_next got %0d wr=%0d exp 14/1", o_data, o_wr); end
   endtask

   task automatic test_random_back_to_back();
      logic [2:0]  f3;
      logic [31:0] a, b;
      logic [5:0]  r;
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = rand_opnd();
         b  = rand_opnd();
         r  = 6'($urandom_range(1, 63));
         run_op(f3, a, b, r, -1, -1);
         checks++; if (o_data !== ref_op(f3, a, b))
            begin errors++; $display("FAIL rand_%0d f3=%0d a=%h b=%h got %h exp %h", i, f3, a, b, o_data, ref_op(f3, a, b)); end
         checks++; if (o_lat !== exp_lat(f3) || o_wr !== 1 || o_reg !== r)
            begin errors++; $display("FAIL rand_timing_%0d got lat=%0d wr=%0d rd=%0d exp %0d/1/%0d", i, o_lat, o_wr, o_reg, exp_lat(f3), r); end
      end
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_mulh();
      test_div();
      test_corner();
      test_rd0();
      test_ignored_start();
      test_flush();
      test_reset_mid();
      test_random_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
